// File: rtl/sw_reader.sv
// sw_reader: synchronizes and debounces the active-low switch bank into active-high levels,
// press pulses and a handshaked event mask. Define SW_READER_RELEASE_EN for release pulses.
module sw_reader #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             slowclk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_level,
   output logic [WIDTH-1:0] sw_press,
`ifdef SW_READER_RELEASE_EN
   output logic [WIDTH-1:0] sw_release,
`endif
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [WIDTH-1:0] evt_mask
);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] r_s1, r_s2, r_level, r_press, r_mask;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0] w_events;
   logic             w_valid;
`ifdef SW_READER_RELEASE_EN
   logic [WIDTH-1:0] r_release;
   assign w_events   = r_press | r_release;
   assign sw_release = r_release;
`else
   assign w_events = r_press;
`endif
   assign w_valid   = |r_mask;
   assign evt_valid = w_valid;
   assign evt_mask  = r_mask;
   assign sw_level  = r_level;
   assign sw_press  = r_press;
   always_ff @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_level <= '0;
         r_press <= '0;
         r_mask  <= '0;
`ifdef SW_READER_RELEASE_EN
         r_release <= '0;
`endif
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         r_s1   <= ~sw_in;
         r_s2   <= r_s1;
         // an event arriving in the handshake cycle survives into the next mask
         r_mask <= (w_valid && evt_ready ? '0 : r_mask) | w_events;
         for (int i = 0; i < WIDTH; i++) begin
            r_press[i] <= 1'b0;
`ifdef SW_READER_RELEASE_EN
            r_release[i] <= 1'b0;
`endif
            if (r_s2[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
               r_level[i] <= r_s2[i];
               r_press[i] <= r_s2[i];
`ifdef SW_READER_RELEASE_EN
               r_release[i] <= ~r_s2[i];
`endif
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sw_reader.sv
// tb_sw_reader: directed and randomized checks of sw_reader against a sample-window model.
// Build with SW_READER_RELEASE_EN to exercise the release variant.
module tb_sw_reader;
   localparam int W = 8;
   localparam int D = 4;
   logic         slowclk = 1'b0;
   logic         rst_n   = 1'b0;
   logic [W-1:0] sw_in   = '1;
   logic         evt_ready = 1'b0;
   logic [W-1:0] sw_level, sw_press, evt_mask;
   logic         evt_valid;
`ifdef SW_READER_RELEASE_EN
   logic [W-1:0] sw_release;
   localparam bit REL = 1'b1;
`else
   logic [W-1:0] sw_release;
   assign sw_release = '0;
   localparam bit REL = 1'b0;
`endif
   int n_chk = 0;
   int n_err = 0;
   int press3_cnt = 0;
   int press_any_cnt = 0;

   sw_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .slowclk   (slowclk),
      .rst_n     (rst_n),
      .sw_in     (sw_in),
      .sw_level  (sw_level),
      .sw_press  (sw_press),
`ifdef SW_READER_RELEASE_EN
      .sw_release(sw_release),
`endif
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_mask  (evt_mask)
   );

   always #5 slowclk = ~slowclk;

   // Model: a bit's level flips once its last D synchronized samples all disagree with it.
   logic [W-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_mask, flip;
   logic [W-1:0] hist [$];
   always @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_mask = '0;
         hist.delete();
      end else begin
         m_mask = ((|m_mask && evt_ready) ? '0 : m_mask) | m_press;
         if (REL) m_mask = m_mask | m_rel;
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         flip = '0;
         if (hist.size() == D)
            for (int b = 0; b < W; b++) begin
               flip[b] = 1'b1;
               for (int k = 0; k < D; k++) if (hist[k][b] == m_level[b]) flip[b] = 1'b0;
            end
         m_press = flip & ~m_level;
         m_rel   = REL ? (flip & m_level) : '0;
         m_level = m_level ^ flip;
         m_s2 = m_s1;
         m_s1 = ~sw_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge slowclk) begin
      chk("level", 32'(sw_level), 32'(m_level));
      chk("press", 32'(sw_press), 32'(m_press));
      chk("release", 32'(sw_release), 32'(m_rel));
      chk("mask", 32'(evt_mask), 32'(m_mask));
      chk("valid", 32'(evt_valid), 32'(|m_mask));
      if (sw_press[3]) press3_cnt++;
      if (|sw_press) press_any_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge slowclk);
   endtask

   task automatic accept();
      evt_ready = 1'b1; step(1); evt_ready = 1'b0;
   endtask

   initial begin
      step(3);
      rst_n = 1'b1;
      step(2);
      chk("rst_level", 32'(sw_level), 32'h0);
      chk("rst_press", 32'(sw_press), 32'h0);
      chk("rst_mask", 32'(evt_mask), 32'h0);
      chk("rst_valid", 32'(evt_valid), 32'h0);
      // clean press of bit 0
      sw_in = 8'hFE;
      step(5);
      chk("press_early", 32'(sw_level), 32'h0);
      step(1);
      chk("press_level", 32'(sw_level), 32'h01);
      chk("press_pulse", 32'(sw_press), 32'h01);
      chk("model_level", 32'(m_level), 32'h01);
      step(1);
      chk("press_once", 32'(sw_press), 32'h0);
      chk("press_mask", 32'(evt_mask), 32'h01);
      chk("press_valid", 32'(evt_valid), 32'h1);
      // press on bit 2 lands in the handshake cycle
      sw_in = 8'hFA;
      step(6);
      chk("coll_pulse", 32'(sw_press), 32'h04);
      evt_ready = 1'b1;
      step(1);
      chk("coll_mask", 32'(evt_mask), 32'h04);
      chk("coll_valid", 32'(evt_valid), 32'h1);
      chk("model_coll", 32'(m_mask), 32'h04);
      step(1);
      chk("coll_clear", 32'(evt_mask), 32'h0);
      step(3);
      chk("idle_ready_mask", 32'(evt_mask), 32'h0);
      chk("idle_ready_valid", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;
      // release both
      sw_in = 8'hFF;
      step(6);
      chk("rel_pulse", 32'(sw_release), REL ? 32'h05 : 32'h0);
      step(1);
      chk("rel_mask", 32'(evt_mask), REL ? 32'h05 : 32'h0);
      accept();
      // glitch rejection on bit 3
      sw_in = 8'hF7; step(3);
      sw_in = 8'hFF; step(8);
      chk("glitch_level", 32'(sw_level), 32'h0);
      press3_cnt = 0;
      sw_in = 8'hF7; step(3);
      sw_in = 8'hFF; step(1);
      sw_in = 8'hF7; step(14);
      chk("glitch_one_press", 32'(press3_cnt), 32'd1);
      chk("glitch_level3", 32'(sw_level), 32'h08);
      sw_in = 8'hFF; step(9);
      accept();
      // multi-bit press
      sw_in = 8'h5A;
      step(6);
      chk("multi_pulse", 32'(sw_press), 32'hA5);
      chk("multi_level", 32'(sw_level), 32'hA5);
      step(1);
      chk("multi_mask", 32'(evt_mask), 32'hA5);
      accept();
      // reset while releasing
      sw_in = 8'hFF;
      step(3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_level", 32'(sw_level), 32'h0);
      chk("async_mask", 32'(evt_mask), 32'h0);
      chk("async_valid", 32'(evt_valid), 32'h0);
      step(2);
      rst_n = 1'b1;
      press_any_cnt = 0;
      step(12);
      chk("no_press_after_rst", 32'(press_any_cnt), 32'd0);
      // repeated presses of bit 0 collapse
      sw_in = 8'hFE; step(7);
      sw_in = 8'hFF; step(7);
      sw_in = 8'hFE; step(7);
      chk("collapse_mask", 32'(evt_mask), 32'h01);
      accept();
      chk("collapse_clear", 32'(evt_mask), 32'h0);
      sw_in = 8'hFF;
      step(6);
      chk("rel0_pulse", 32'(sw_release), REL ? 32'h01 : 32'h0);
      step(1);
      chk("rel0_mask", 32'(evt_mask), REL ? 32'h01 : 32'h0);
      accept();
      // randomized phase: slow bit toggles, random ready, rare resets
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(3) == 0) sw_in[$urandom_range(W-1)] ^= 1'b1;
         evt_ready = ($urandom_range(2) == 0);
         if ($urandom_range(299) == 0) begin
            #2 rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end else step(1);
      end
      step(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
